// File: rtl/exu_mdu.sv
// exu_mdu: iterative RV32M/RV64M multiply/divide unit with valid/ready and flush.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; divides stay iterative.
module exu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] instr_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wr_en,
  output logic [XLEN-1:0] out_instr_tag,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;
  logic [CW-1:0]     cnt;

  logic              sa, sb, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div0, ovf;
  logic [XLEN-1:0]   spec_res;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (1'b1)
      op == 3'd1, op == 3'd4, op == 3'd6: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      op == 3'd2: sa = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sa & rs1_data[XLEN-1];
  assign b_neg = sb & rs2_data[XLEN-1];
  assign a_mag = a_neg ? -rs1_data : rs1_data;
  assign b_mag = b_neg ? -rs2_data : rs2_data;

  assign div0 = op[2] & (rs2_data == '0);
  assign ovf  = op[2] & ~op[0] & (rs1_data == MIN) & (&rs2_data);

  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = op[1] ? rs1_data : '1;
    else if (ovf)
      spec_res = op[1] ? '0 : MIN;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fp;
  logic [XLEN-1:0]   fast_res;
  assign fa = {{XLEN{a_neg}}, rs1_data};
  assign fb = {{XLEN{b_neg}}, rs2_data};
  assign fp = fa * fb;
  assign fast_res = (op == 3'd0) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`endif

  // One bit per cycle: acc = {high/remainder, low/quotient}
  logic [XLEN:0]     msum, dsh, ddiff;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0]   quo, rmd, fin;

  always_comb begin
    msum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    dsh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ddiff = dsh - {1'b0, b_q};
    if (!op_q[2])
      step = {msum, acc[XLEN-1:1]};
    else if (ddiff[XLEN])
      step = {dsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      step = {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  assign prod = neg_q ? -step : step;
  assign quo  = step[XLEN-1:0];
  assign rmd  = step[2*XLEN-1:XLEN];

  always_comb begin
    unique case (op_q)
      3'd0:    fin = prod[XLEN-1:0];
      3'd4:    fin = neg_q ? -quo : quo;
      3'd5:    fin = quo;
      3'd6:    fin = neg_r ? -rmd : rmd;
      3'd7:    fin = rmd;
      default: fin = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign in_ready     = (state == IDLE) & ~flush;
  assign busy         = (state != IDLE);
  assign out_rd_wr_en = out_valid & (out_rd_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      b_q           <= '0;
      acc           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      cnt           <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd_addr   <= '0;
      out_instr_tag <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q          <= op;
          b_q           <= b_mag;
          acc           <= {{XLEN{1'b0}}, a_mag};
          neg_q         <= a_neg ^ b_neg;
          neg_r         <= a_neg;
          cnt           <= '0;
          out_rd_addr   <= rd_addr;
          out_instr_tag <= instr_tag;
          if (div0 | ovf) begin
            out_data  <= spec_res;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef MDU_FAST_MUL_EN
          end else if (!op[2]) begin
            out_data  <= fast_res;
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_data  <= fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/exu_mdu.md
# exu_mdu

Parametrised multiply/divide execution unit implementing the RV32M/RV64M operations. Sits beside the single-cycle ALU in the execute stage and takes the same decoded operands (rs1/rs2 data, rd address, instruction tag). Unlike the ALU, it is multi-cycle. It uses a valid/ready handshake on both sides, an internal state machine, an iterative datapath and flush support. Its registered result feeds the writeback arbiter.

## Interface
Parameters:
- XLEN, 32, operand/result width (32 or 64).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; equals (state==IDLE) & ~flush.
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  in  XLEN  dividend / multiplicand.
- rs2_data  in  XLEN  divisor / multiplier.
- rd_addr  in  5  destination register.
- instr_tag  in  XLEN  instruction tag (PC), carried through unchanged.
- flush  in  1  kill any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- out_data  out  XLEN  result.
- out_rd_addr  out  5  registered rd_addr.
- out_rd_wr_en  out  1  out_valid & (out_rd_addr != 0).
- out_instr_tag  out  XLEN  registered instr_tag.
- busy  out  1  state != IDLE.

## Operation
- State machine: IDLE, CALC, DONE.
- IDLE:
  - Accept when in_valid & in_ready.
  - Latch op, operand magnitudes, sign flags, rd_addr and instr_tag.
  - Next state is CALC. Special cases go straight to DONE.
- CALC:
  - A cycle counter runs 0..XLEN-1.
  - Each cycle retires one bit: shift-add for multiply, restoring subtract for divide.
  - At count XLEN-1, apply the sign fix-up, register out_data, and go to DONE.
- DONE:
  - out_valid=1; all out_* fields are held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in this state, so no accept can happen in the same cycle.
- Multiply:
  - Operands are treated as signed or unsigned per op; MULHSU has rs1 signed, rs2 unsigned.
  - The unit multiplies magnitudes into a 2·XLEN product, then negates the product if the operand signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Unsigned division on magnitudes.
  - DIV quotient is negated if the operand signs differ. REM remainder takes the sign of the dividend.
- Special cases: skip CALC and go to DONE on the next edge.
  - Divisor zero: quotient all-ones; remainder = rs1_data.
  - Signed overflow (DIV/REM with rs1 = most-negative and rs2 = -1): quotient = most-negative; remainder 0.
- Flush:
  - From any state, the unit returns to IDLE on the next edge and discards the result.
  - out_valid drops on that edge.
  - If flush and in_valid are high together, flush wins and nothing is accepted.

## Timing
- Reset (asynchronous) puts the unit in IDLE. Reset values:
  - out_valid=0, out_rd_wr_en=0.
  - out_data=0, out_rd_addr=0, out_instr_tag=0.
  - busy=0; in_ready=1 once rst_n is high and flush=0.
- Reset mid-operation aborts immediately; no output is produced.
- Accept at edge T. Normal ops:
  - CALC occupies cycles T+1 .. T+XLEN.
  - out_valid is high from cycle T+XLEN+1.
  - Total latency is XLEN+1 cycles (33 for XLEN=32).
- Special-case divides: out_valid from cycle T+1.
- Back-to-back throughput: the next accept is at the earliest one cycle after the out_valid&out_ready handshake.
- out_valid never drops without a handshake except on flush or reset.

## Configuration
- MDU_FAST_MUL_EN:
  - When defined, multiplies use a single-cycle XLEN×XLEN array (behavioural `*` on sign-extended operands) and go IDLE→DONE.
  - Multiply out_valid is then at T+1. Divides are unchanged.
  - When undefined, multiplies use the iterative path with XLEN+1 latency.

## Test plan
- MUL 7 × 0xFFFFFFFD (XLEN=32), out_ready=1:
  - out_data=0xFFFFFFEB at T+33 (T+1 with MDU_FAST_MUL_EN).
  - out_rd_addr and out_instr_tag match the request.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2. Each at T+33.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0. All special cases at T+1.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles after out_valid; out_data must stay stable and in_ready must stay 0.
  - Raise out_ready; in_ready=1 on the next cycle.
- Flush and reset:
  - Assert flush at CALC count 10: busy=0 next cycle, no out_valid ever for that op.
  - A flush coinciding with in_valid is not accepted.
  - Assert rst_n=0 mid-CALC: all outputs reach their reset values immediately.
